ddr3_port_arbiter: RTL and testbench
====================================

DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of client channels (range 1..8).
REQ-002 SHALL have parameter ADDR_W, default 27, memory byte-address width.
REQ-003 SHALL have parameter DATA_W, default 128, one full DDR3 burst (16-bit x BL8).
REQ-004 SHALL have parameter RD_DEPTH, default 8, maximum outstanding reads (power of 2).
REQ-005 SHALL use one clock and one reset; reset is synchronous and active-high.
- sys_clk  in  1  memory UI clock; all logic on rising edge
- sys_rst  in  1  synchronous active-high reset
- ch_req  in  N_CH  per-channel request, held until granted
- ch_we  in  N_CH  1 = write, 0 = read
- ch_addr  in  N_CH x ADDR_W  request address
- ch_wdata  in  N_CH x DATA_W  write data
- ch_gnt  out  N_CH  one-cycle pulse: command accepted by memory
- ch_rvalid  out  N_CH  one-hot: rd_data belongs to this channel
- rd_data  out  DATA_W  read data, shared by all channels
- init_calib_complete  in  1  memory ready
- app_en, app_cmd[2:0], app_addr[ADDR_W]  out  command port
- app_rdy  in  1  command accepted
- app_wdf_wren, app_wdf_end  out  1  write-data strobes
- app_wdf_data  out  DATA_W  write data
- app_wdf_rdy  in  1  write-data accepted
- app_rd_data  in  DATA_W; app_rd_data_valid  in  1  read return
- err_orphan  out  1  sticky: read data arrived with no tag outstanding

Function
REQ-006 SHALL implement states CALIB, ARB, WDATA, CMD.
REQ-007 CALIB -> ARB when init_calib_complete=1; no output activity in CALIB.
REQ-008 ARB: round-robin search starting at channel (last_grant+1) mod N_CH; first eligible channel wins; latch its we/addr/wdata and index the same cycle.
REQ-009 A channel is eligible if ch_req=1 and (ch_we=1 or tag FIFO not full).
REQ-010 Winner with we=1 -> WDATA; we=0 -> CMD; no eligible channel -> stay in ARB.
REQ-011 WDATA: app_wdf_wren=app_wdf_end=1 with latched data until app_wdf_rdy=1 is sampled, then -> CMD.
REQ-012 CMD: app_en=1, app_cmd = WRITE (000) or READ (001), app_addr = latched address, held stable until app_rdy=1 is sampled.
REQ-013 On the app_en&&app_rdy cycle: ch_gnt[winner] pulses for that cycle only, last_grant := winner, reads push winner index into tag FIFO, state -> ARB.
REQ-014 Minimum turnaround: a read takes 2 cycles ARB-to-ARB, a write 3, when ready signals are already high.
REQ-015 Read return: each cycle with app_rd_data_valid=1 SHALL pop the tag FIFO and, registered one cycle later, drive rd_data and one-hot ch_rvalid[tag].
REQ-016 Simultaneous push and pop in one cycle SHALL leave the count unchanged; FIFO pointers wrap modulo RD_DEPTH.
REQ-017 app_rd_data_valid with FIFO empty SHALL drop the data, assert no ch_rvalid, and set err_orphan until reset.
REQ-018 Clients SHALL keep ch_we/ch_addr/ch_wdata stable while ch_req=1; dropping ch_req before ch_gnt is a protocol violation with undefined result.
REQ-019 init_calib_complete falling SHALL NOT abort a command in progress; after it completes, next state is CALIB.

Reset
REQ-020 On sys_rst: state CALIB; app_en, app_wdf_wren, app_wdf_end, ch_gnt, ch_rvalid, err_orphan = 0; app_cmd, app_addr, app_wdf_data, rd_data = 0; last_grant = N_CH-1; tag FIFO empty.
REQ-021 Reset mid-operation SHALL abandon any in-flight command; reads returning after reset are orphans per REQ-017.

Structure
REQ-022 Package ddr3_arb_pkg SHALL hold the state enum and the command codes CMD_WRITE=3'b000, CMD_READ=3'b001.
REQ-023 The tag FIFO SHALL be a sub-module arb_tag_fifo (width clog2(N_CH), depth RD_DEPTH, full/empty flags, synchronous reset).

Verification
REQ-024 Calib hold: init_calib_complete=0, ch_req=4'b1111 for 50 cycles -> app_en=0, no ch_gnt.
REQ-025 Round robin: all 4 channels read continuously, app_rdy=1 -> grant order 0,1,2,3,0,... each granted once per 8 cycles.
REQ-026 Write: ch2 we=1, addr=0x0000100, wdata=0xA5..A5, app_wdf_rdy low 3 cycles -> wren held 4 cycles, then app_en with cmd 000 addr 0x0000100, ch_gnt[2] single pulse.
REQ-027 Read routing: ch1 then ch3 reads; memory returns D1, D3 -> ch_rvalid=0010 with D1, then 1000 with D3, each one cycle after app_rd_data_valid.
REQ-028 Full FIFO: 8 reads outstanding, ch0 read + ch1 write pending -> ch1 granted, ch0 blocked until first read returns.
REQ-029 Orphan/reset: sys_rst asserted with 2 reads outstanding, 2 returns after -> no ch_rvalid, err_orphan=1.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg: shared types and constants for the DDR3 port arbiter.
//   arb_state_t : arbiter FSM state encoding (StCalib, StArb, StWdata, StCmd)
//   CMD_WRITE / CMD_READ : app_cmd encodings for the memory UI command port
//   tag_w()     : width of a channel index, never less than one bit
package ddr3_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t StCalib = 2'd0;
  localparam arb_state_t StArb   = 2'd1;
  localparam arb_state_t StWdata = 2'd2;
  localparam arb_state_t StCmd   = 2'd3;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  function automatic int unsigned tag_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr3_port_arbiter_if.sv
// ddr3_port_arbiter_if: client-side and memory-UI-side signal bundle of the arbiter.
//   ch_*      : per-channel request / grant / read-return signals
//   app_*     : memory controller command, write-data and read-return ports
//   rd_data   : read data shared by all channels
// Modports: master = arbiter view, slave = clients plus memory controller view.
interface ddr3_port_arbiter_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 128
);

  logic [N_CH-1:0]             ch_req;
  logic [N_CH-1:0]             ch_we;
  logic [N_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [N_CH-1:0][DATA_W-1:0] ch_wdata;
  logic [N_CH-1:0]             ch_gnt;
  logic [N_CH-1:0]             ch_rvalid;
  logic [DATA_W-1:0]           rd_data;

  logic                        app_en;
  logic [2:0]                  app_cmd;
  logic [ADDR_W-1:0]           app_addr;
  logic                        app_rdy;
  logic                        app_wdf_wren;
  logic                        app_wdf_end;
  logic [DATA_W-1:0]           app_wdf_data;
  logic                        app_wdf_rdy;
  logic [DATA_W-1:0]           app_rd_data;
  logic                        app_rd_data_valid;

  modport master (
    input  ch_req, ch_we, ch_addr, ch_wdata,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output ch_gnt, ch_rvalid, rd_data,
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data
  );

  modport slave (
    output ch_req, ch_we, ch_addr, ch_wdata,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  ch_gnt, ch_rvalid, rd_data,
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data
  );

endinterface

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: small synchronous FIFO holding the channel index of each outstanding read.
//   clk_i / rst_i      : clock, synchronous active-high reset (empties the FIFO)
//   push_i/push_data_i : enqueue a tag (ignored when full)
//   pop_i / pop_data_o : dequeue; pop_data_o shows the head tag combinationally
//   full_o / empty_o   : occupancy flags
module arb_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == (PtrW + 1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// ddr3_port_arbiter: round-robin arbiter multiplexing N_CH clients onto one DDR3 UI port.
//   sys_clk / sys_rst    : UI clock, synchronous active-high reset
//   init_calib_complete  : memory ready; arbitration only runs while high
//   err_orphan           : sticky flag, read data returned with no tag outstanding
//   bus (master)         : client request/grant/read-return and app_* command ports
// Reads record the requesting channel in a tag FIFO so returned data can be routed back.
module ddr3_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned ADDR_W   = 27,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned RD_DEPTH = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 init_calib_complete,
  output logic                 err_orphan,
  ddr3_port_arbiter_if.master  bus
);

  localparam int unsigned TagW = tag_w(N_CH);

  arb_state_t        state_q, state_d;
  logic [TagW-1:0]   last_q, last_d;
  logic [TagW-1:0]   win_q, win_d;
  logic              we_q, we_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [N_CH-1:0]   elig;
  logic              found;
  logic [TagW-1:0]   pick;
  logic [31:0]       idx;
  logic              accept;
  logic [N_CH-1:0]   gnt;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [TagW-1:0]   pop_tag;
  logic [N_CH-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              orphan_q;

  // Writes never occupy a tag, so they stay eligible while the FIFO is full.
  assign elig = bus.ch_req & (bus.ch_we | {N_CH{~fifo_full}});

  // Walk from the farthest offset back to last+1 so the nearest eligible channel wins.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = '0;
    for (int unsigned k = N_CH; k >= 1; k--) begin
      idx = (32'(last_q) + k) % N_CH;
      if (elig[idx[TagW-1:0]]) begin
        found = 1'b1;
        pick  = idx[TagW-1:0];
      end
    end
  end

  assign accept = (state_q == StCmd) && bus.app_rdy;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StCalib: if (init_calib_complete) state_d = StArb;
      StArb: begin
        if (!init_calib_complete) begin
          state_d = StCalib;
        end else if (found) begin
          win_d   = pick;
          we_d    = bus.ch_we[pick];
          cmd_d   = bus.ch_we[pick] ? CMD_WRITE : CMD_READ;
          addr_d  = bus.ch_addr[pick];
          wdata_d = bus.ch_wdata[pick];
          state_d = bus.ch_we[pick] ? StWdata : StCmd;
        end
      end
      StWdata: if (bus.app_wdf_rdy) state_d = StCmd;
      StCmd: begin
        // A command already issued always completes; calibration loss is honoured after.
        if (bus.app_rdy) begin
          last_d  = win_q;
          state_d = init_calib_complete ? StArb : StCalib;
        end
      end
      default: state_d = StCalib;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StCalib;
      last_q  <= TagW'(N_CH - 1);
      win_q   <= '0;
      we_q    <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (accept) gnt[win_q] = 1'b1;
  end

  arb_tag_fifo #(
    .WIDTH (TagW),
    .DEPTH (RD_DEPTH)
  ) u_tag_fifo (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .push_i      (accept && !we_q),
    .push_data_i (win_q),
    .pop_i       (fifo_pop),
    .pop_data_o  (pop_tag),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign fifo_pop = bus.app_rd_data_valid && !fifo_empty;

  always_comb begin
    rvalid_d = '0;
    if (fifo_pop) rvalid_d[pop_tag] = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rvalid_q  <= '0;
      rd_data_q <= '0;
      orphan_q  <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      if (fifo_pop) rd_data_q <= bus.app_rd_data;
      if (bus.app_rd_data_valid && fifo_empty) orphan_q <= 1'b1;
    end
  end

  assign bus.app_en       = (state_q == StCmd);
  assign bus.app_cmd      = cmd_q;
  assign bus.app_addr     = addr_q;
  assign bus.app_wdf_wren = (state_q == StWdata);
  assign bus.app_wdf_end  = (state_q == StWdata);
  assign bus.app_wdf_data = wdata_q;
  assign bus.ch_gnt       = gnt;
  assign bus.ch_rvalid    = rvalid_q;
  assign bus.rd_data      = rd_data_q;
  assign err_orphan       = orphan_q;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// tb_ddr3_port_arbiter: scenario bench for ddr3_port_arbiter with a read-return scoreboard.
module tb_ddr3_port_arbiter;
  import ddr3_arb_pkg::*;

  localparam int unsigned NCh   = 4;
  localparam int unsigned AddrW = 27;
  localparam int unsigned DataW = 128;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic init_calib_complete;
  logic err_orphan;

  ddr3_port_arbiter_if #(.N_CH(NCh), .ADDR_W(AddrW), .DATA_W(DataW)) bus ();

  ddr3_port_arbiter #(
    .N_CH     (NCh),
    .ADDR_W   (AddrW),
    .DATA_W   (DataW),
    .RD_DEPTH (8)
  ) dut (
    .sys_clk             (sys_clk),
    .sys_rst             (sys_rst),
    .init_calib_complete (init_calib_complete),
    .err_orphan          (err_orphan),
    .bus                 (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [1:0]       exp_tag_q[$];
  logic [DataW-1:0] exp_data_q[$];
  logic [NCh-1:0]   exp_gnt_q[$];

  task automatic wait_gnt(input int bound, output logic [NCh-1:0] g, output int at);
    g  = '0;
    at = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge sys_clk);
      if (bus.ch_gnt != '0) begin
        g  = bus.ch_gnt;
        at = cyc;
        return;
      end
    end
  endtask

  // Back-to-back read returns; each response is checked one cycle after its valid.
  task automatic drive_returns(input int n);
    logic [DataW-1:0] d, ed;
    logic [1:0]       t;
    logic [NCh-1:0]   er;
    for (int i = 0; i <= n; i++) begin
      @(negedge sys_clk);
      if (i > 0) begin
        checks++;
        if (exp_tag_q.size() == 0 || exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL ret_scoreboard: return %0d has no expected entry", i);
        end else begin
          t  = exp_tag_q.pop_front();
          ed = exp_data_q.pop_front();
          er = '0;
          er[t] = 1'b1;
          if (bus.ch_rvalid !== er) begin
            errors++;
            $display("FAIL ret_rvalid[%0d]: got %b expected %b", i, bus.ch_rvalid, er);
          end
          checks++;
          if (bus.rd_data !== ed) begin
            errors++;
            $display("FAIL ret_data[%0d]: got %h expected %h", i, bus.rd_data, ed);
          end
        end
      end
      if (i < n) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        exp_data_q.push_back(d);
        bus.app_rd_data       = d;
        bus.app_rd_data_valid = 1'b1;
      end else begin
        bus.app_rd_data_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    init_calib_complete = 1'b0;
    bus.ch_req = '0;
    bus.ch_we = '0;
    bus.ch_addr = '0;
    bus.ch_wdata = '0;
    bus.app_rdy = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    bus.app_rd_data = '0;
    bus.app_rd_data_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (bus.app_en !== 1'b0) begin errors++; $display("FAIL rst_app_en: got %b expected 0", bus.app_en); end
    checks++; if ({bus.app_wdf_wren, bus.app_wdf_end} !== 2'b00) begin
      errors++; $display("FAIL rst_wdf: got %b%b expected 00", bus.app_wdf_wren, bus.app_wdf_end); end
    checks++; if (bus.ch_gnt !== '0) begin errors++; $display("FAIL rst_gnt: got %b expected 0", bus.ch_gnt); end
    checks++; if (bus.ch_rvalid !== '0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", bus.ch_rvalid); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rst_orphan: got %b expected 0", err_orphan); end
    checks++; if (bus.app_cmd !== 3'b000) begin errors++; $display("FAIL rst_cmd: got %b expected 000", bus.app_cmd); end
    checks++; if (bus.app_addr !== '0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bus.app_addr); end
    checks++; if (bus.app_wdf_data !== '0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", bus.app_wdf_data); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL rst_rd_data: got %h expected 0", bus.rd_data); end
    sys_rst = 1'b0;
  endtask

  task automatic test_calib_hold();
    for (int c = 0; c < NCh; c++) begin
      bus.ch_addr[c] = AddrW'(32'h1000 + c);
      bus.ch_we[c]   = 1'b0;
    end
    bus.ch_req = 4'b1111;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      checks++;
      if (bus.app_en !== 1'b0 || bus.ch_gnt !== '0 || bus.app_wdf_wren !== 1'b0) begin
        errors++;
        $display("FAIL calib_hold[%0d]: app_en %b gnt %b wren %b expected all 0",
                 i, bus.app_en, bus.ch_gnt, bus.app_wdf_wren);
      end
    end
  endtask

  task automatic test_round_robin();
    int             left[NCh];
    int             at, last_at;
    logic [NCh-1:0] g, e;
    last_at = 0;
    for (int c = 0; c < NCh; c++) left[c] = 2;
    for (int k = 0; k < 8; k++) begin
      e = '0;
      e[k % 4] = 1'b1;
      exp_gnt_q.push_back(e);
      exp_tag_q.push_back(2'(k % 4));
    end
    init_calib_complete = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_gnt(10, g, at);
      e = exp_gnt_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, g, e); end
      checks++;
      if (bus.app_cmd !== CMD_READ || bus.app_addr !== AddrW'(32'h1000 + k % 4)) begin
        errors++;
        $display("FAIL rr_cmd[%0d]: cmd %b addr %h expected 001 %h", k, bus.app_cmd,
                 bus.app_addr, 32'h1000 + k % 4);
      end
      if (k > 0) begin
        checks++;
        if (at - last_at != 2) begin
          errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected 2", k, at - last_at);
        end
      end
      last_at = at;
      for (int c = 0; c < NCh; c++) begin
        if (g[c]) begin
          left[c]--;
          if (left[c] == 0) bus.ch_req[c] = 1'b0;
        end
      end
    end
  endtask

  // Eight reads are outstanding from the round-robin test.
  task automatic test_full_fifo();
    logic [NCh-1:0] g;
    int             at;
    bus.ch_we[0]    = 1'b0;
    bus.ch_addr[0]  = AddrW'(32'h2000);
    bus.ch_we[1]    = 1'b1;
    bus.ch_addr[1]  = AddrW'(32'h3000);
    bus.ch_wdata[1] = {4{32'hC0DE0001}};
    bus.ch_req      = 4'b0011;
    wait_gnt(10, g, at);
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL full_write_gnt: got %b expected 0010", g); end
    bus.ch_req[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      checks++;
      if (bus.ch_gnt !== '0) begin
        errors++; $display("FAIL full_blocked[%0d]: got %b expected 0000", i, bus.ch_gnt);
      end
    end
    drive_returns(1);
    exp_tag_q.push_back(2'd0);
    wait_gnt(10, g, at);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL full_read_gnt: got %b expected 0001", g); end
    bus.ch_req[0] = 1'b0;
    drive_returns(8);
  endtask

  task automatic test_write();
    int wcnt, ecnt, gcnt;
    wcnt = 0; ecnt = 0; gcnt = 0;
    bus.ch_we[2]    = 1'b1;
    bus.ch_addr[2]  = AddrW'(32'h0000100);
    bus.ch_wdata[2] = {16{8'hA5}};
    bus.app_wdf_rdy = 1'b0;
    bus.ch_req      = 4'b0100;
    for (int i = 0; i < 15; i++) begin
      @(negedge sys_clk);
      if (bus.app_wdf_wren) begin
        wcnt++;
        checks++;
        if (bus.app_wdf_end !== 1'b1 || bus.app_wdf_data !== {16{8'hA5}}) begin
          errors++;
          $display("FAIL wr_data: end %b data %h expected 1 %h", bus.app_wdf_end,
                   bus.app_wdf_data, {16{8'hA5}});
        end
      end
      if (bus.app_en) begin
        ecnt++;
        checks++;
        if (bus.app_cmd !== CMD_WRITE || bus.app_addr !== AddrW'(32'h100)) begin
          errors++;
          $display("FAIL wr_cmd: cmd %b addr %h expected 000 0000100", bus.app_cmd, bus.app_addr);
        end
      end
      if (bus.ch_gnt != '0) begin
        gcnt++;
        checks++;
        if (bus.ch_gnt !== 4'b0100) begin
          errors++; $display("FAIL wr_gnt: got %b expected 0100", bus.ch_gnt);
        end
        bus.ch_req[2] = 1'b0;
      end
      bus.app_wdf_rdy = (wcnt >= 4);
    end
    checks++; if (wcnt != 4) begin errors++; $display("FAIL wr_wren_cycles: got %0d expected 4", wcnt); end
    checks++; if (ecnt != 1) begin errors++; $display("FAIL wr_en_cycles: got %0d expected 1", ecnt); end
    checks++; if (gcnt != 1) begin errors++; $display("FAIL wr_gnt_pulses: got %0d expected 1", gcnt); end
    bus.app_wdf_rdy = 1'b1;
  endtask

  task automatic test_read_routing();
    logic [NCh-1:0] g;
    int             at;
    bus.ch_we = '0;
    bus.ch_addr[1] = AddrW'(32'h11);
    bus.ch_addr[3] = AddrW'(32'h33);
    bus.ch_req = 4'b0010;
    wait_gnt(10, g, at);
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL route_gnt1: got %b expected 0010", g); end
    bus.ch_req[1] = 1'b0;
    exp_tag_q.push_back(2'd1);
    bus.ch_req[3] = 1'b1;
    wait_gnt(10, g, at);
    checks++;
    if (g !== 4'b1000) begin errors++; $display("FAIL route_gnt3: got %b expected 1000", g); end
    bus.ch_req[3] = 1'b0;
    exp_tag_q.push_back(2'd3);
    drive_returns(2);
    @(negedge sys_clk);
    checks++;
    if (bus.ch_rvalid !== '0) begin
      errors++; $display("FAIL route_idle: got %b expected 0000", bus.ch_rvalid);
    end
  endtask

  task automatic test_orphan_reset();
    logic [NCh-1:0] g;
    int             gcnt;
    gcnt = 0;
    bus.ch_we  = '0;
    bus.ch_req = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      g = bus.ch_gnt;
      if (g != '0) begin
        gcnt++;
        bus.ch_req = bus.ch_req & ~g;
      end
    end
    checks++; if (gcnt != 2) begin errors++; $display("FAIL orph_grants: got %0d expected 2", gcnt); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orph_pre: got %b expected 0", err_orphan); end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      checks++;
      if (bus.ch_rvalid !== '0) begin
        errors++; $display("FAIL orph_rvalid[%0d]: got %b expected 0000", i, bus.ch_rvalid);
      end
      bus.app_rd_data       = {4{$urandom}};
      bus.app_rd_data_valid = (i < 2);
    end
    checks++;
    if (err_orphan !== 1'b1) begin errors++; $display("FAIL orph_flag: got %b expected 1", err_orphan); end
  endtask

  initial begin
    test_reset();
    test_calib_hold();
    test_round_robin();
    test_full_fifo();
    test_write();
    test_read_routing();
    test_orphan_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
